seq_mantissa_alu: RTL and testbench

Parametrised sequential mantissa ALU for the floating-point datapath. It performs single-cycle unsigned add and multi-cycle radix-2 shift-and-add multiply or multiply-accumulate on WIDTH-bit mantissas. It replaces the fixed 23-bit, externally-muxed repeated-addition ALU with an internal state machine and a start/done handshake. It sits between the FP unpack stage and the normalise/round stage.

---
 rtl/seq_mantissa_alu_if.sv | 17 +
 rtl/seq_mantissa_alu.sv | 151 +++++++++++++++
 tb/tb_seq_mantissa_alu.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/seq_mantissa_alu_if.sv
// Start/done handshake and operand/result bundle for seq_mantissa_alu.
// master drives requests, slave is the ALU.
interface seq_mantissa_alu_if #(
  parameter int unsigned WIDTH = 23
);
  logic               start;
  logic [1:0]         op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] result;
  logic               overflow;

  modport master (output start, op, a, b, input busy, done, result, overflow);
  modport slave  (input start, op, a, b, output busy, done, result, overflow);
endinterface

// File: rtl/seq_mantissa_alu.sv
// Sequential mantissa ALU: 1-cycle ADD/CLR, radix-2 shift-and-add MUL/MAC.
// Optional MANTISSA_ALU_EARLY_EXIT_EN ends MUL/MAC once no multiplier bits remain.
module seq_mantissa_alu #(
  parameter int unsigned WIDTH = 23
) (
  input logic              clk,
  input logic              rst_n,
  seq_mantissa_alu_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned W2    = 2 * WIDTH;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMul  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpMul = 2'b01;
  localparam logic [1:0] OpMac = 2'b10;
  localparam logic [1:0] OpClr = 2'b11;

  logic [1:0]       state_q, state_d;
  logic             is_mac_q, is_mac_d;
  logic [W2-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [W2-1:0]    result_q, result_d;
  logic             overflow_q, overflow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [W2:0]      sum;
  logic             last_step;
  logic             finish;

  // One partial product per step: multiplicand shifts left, multiplier shifts right.
  always_comb begin
    sum       = {1'b0, acc_q} + {1'b0, (mplier_q[0] ? mcand_q : '0)};
    last_step = (count_q == CNT_W'(WIDTH - 1));
`ifdef MANTISSA_ALU_EARLY_EXIT_EN
    finish    = last_step || ((mplier_q >> 1) == '0);
`else
    finish    = last_step;
`endif
  end

  always_comb begin
    state_d    = state_q;
    is_mac_d   = is_mac_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    count_d    = count_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          overflow_d = 1'b0;
          mcand_d    = W2'(bus.a);
          mplier_d   = bus.b;
          count_d    = '0;
          unique case (bus.op)
            OpAdd: begin
              result_d = W2'(bus.a) + W2'(bus.b);
              done_d   = 1'b1;
              state_d  = StDone;
            end
            OpClr: begin
              result_d = '0;
              done_d   = 1'b1;
              state_d  = StDone;
            end
            OpMul: begin
              acc_d    = '0;
              is_mac_d = 1'b0;
              busy_d   = 1'b1;
              state_d  = StMul;
            end
            OpMac: begin
              acc_d    = result_q;
              is_mac_d = 1'b1;
              busy_d   = 1'b1;
              state_d  = StMul;
            end
            default: state_d = StIdle;
          endcase
        end
      end
      StMul: begin
        acc_d    = sum[W2-1:0];
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CNT_W'(1);
        if (is_mac_q) begin
          overflow_d = overflow_q | sum[W2];
        end
        if (finish) begin
          result_d = sum[W2-1:0];
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      is_mac_q   <= 1'b0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      count_q    <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_mac_q   <= is_mac_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_seq_mantissa_alu.sv
// Directed self-checking bench for seq_mantissa_alu at WIDTH=23 and WIDTH=4.
module tb_seq_mantissa_alu;

`ifdef MANTISSA_ALU_EARLY_EXIT_EN
  localparam int LatMul5 = 4;
  localparam int BsyMul5 = 3;
  localparam int LatMul0 = 2;
  localparam int BsyMul0 = 1;
  localparam int LatMac4 = 4;
  localparam int LatRst  = 4;
`else
  localparam int LatMul5 = 24;
  localparam int BsyMul5 = 23;
  localparam int LatMul0 = 24;
  localparam int BsyMul0 = 23;
  localparam int LatMac4 = 24;
  localparam int LatRst  = 24;
`endif

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  seq_mantissa_alu_if #(.WIDTH(23)) bus23 ();
  seq_mantissa_alu_if #(.WIDTH(4))  bus4 ();

  seq_mantissa_alu #(.WIDTH(23)) u_dut23 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus23.slave)
  );

  seq_mantissa_alu #(.WIDTH(4)) u_dut4 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one request, scramble the inputs after acceptance, return at the done cycle.
  task automatic do_op(input bit w4, input logic [1:0] o, input logic [22:0] x,
                       input logic [22:0] y, output int lat, output int bcnt);
    if (w4) begin
      bus4.start = 1'b1; bus4.op = o; bus4.a = x[3:0]; bus4.b = y[3:0];
    end else begin
      bus23.start = 1'b1; bus23.op = o; bus23.a = x; bus23.b = y;
    end
    @(posedge clk); #1;
    bus4.start  = 1'b0; bus4.op  = ~o; bus4.a  = 4'ha;        bus4.b  = 4'h5;
    bus23.start = 1'b0; bus23.op = ~o; bus23.a = 23'h5a5a5a; bus23.b = 23'h2c3c3c;
    lat  = 1;
    bcnt = 0;
    while (!(w4 ? bus4.done : bus23.done) && lat < 100) begin
      if (w4 ? bus4.busy : bus23.busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic done_drops(input bit w4, input string tag);
    @(posedge clk); #1;
    check(tag, 64'(w4 ? bus4.done : bus23.done), 64'd0);
  endtask

  initial begin
    int lat, bcnt, cyc, pulses, first;
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    bus23.start = 1'b0; bus23.op = 2'b00; bus23.a = '0; bus23.b = '0;
    bus4.start  = 1'b0; bus4.op  = 2'b00; bus4.a  = '0; bus4.b  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(bus23.busy), 64'd0);
    check("rst_done", 64'(bus23.done), 64'd0);
    check("rst_result", 64'(bus23.result), 64'd0);
    check("rst_overflow", 64'(bus23.overflow), 64'd0);
    check("rst_result_w4", 64'(bus4.result), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD 20+10
    do_op(1'b0, 2'b00, 23'd20, 23'd10, lat, bcnt);
    check("add_lat", 64'(lat), 64'd1);
    check("add_busy_cycles", 64'(bcnt), 64'd0);
    check("add_busy_at_done", 64'(bus23.busy), 64'd0);
    check("add_result", 64'(bus23.result), 64'd30);
    check("add_overflow", 64'(bus23.overflow), 64'd0);
    done_drops(1'b0, "add_done_pulse");

    // ADD at full width: carry lands in bit 23
    do_op(1'b0, 2'b00, 23'h7fffff, 23'h7fffff, lat, bcnt);
    check("add_max_result", 64'(bus23.result), 64'd16777214);
    check("add_max_overflow", 64'(bus23.overflow), 64'd0);
    done_drops(1'b0, "add_max_done_pulse");

    // MUL 20*5
    do_op(1'b0, 2'b01, 23'd20, 23'd5, lat, bcnt);
    check("mul5_lat", 64'(lat), 64'(LatMul5));
    check("mul5_busy_cycles", 64'(bcnt), 64'(BsyMul5));
    check("mul5_result", 64'(bus23.result), 64'd100);
    check("mul5_busy_at_done", 64'(bus23.busy), 64'd0);
    done_drops(1'b0, "mul5_done_pulse");

    // MUL 20*0
    do_op(1'b0, 2'b01, 23'd20, 23'd0, lat, bcnt);
    check("mul0_lat", 64'(lat), 64'(LatMul0));
    check("mul0_busy_cycles", 64'(bcnt), 64'(BsyMul0));
    check("mul0_result", 64'(bus23.result), 64'd0);
    done_drops(1'b0, "mul0_done_pulse");

    // MAC 3*4 twice accumulates onto result
    do_op(1'b0, 2'b10, 23'd3, 23'd4, lat, bcnt);
    check("mac1_lat", 64'(lat), 64'(LatMac4));
    check("mac1_result", 64'(bus23.result), 64'd12);
    done_drops(1'b0, "mac1_done_pulse");
    do_op(1'b0, 2'b10, 23'd3, 23'd4, lat, bcnt);
    check("mac2_result", 64'(bus23.result), 64'd24);
    check("mac2_overflow", 64'(bus23.overflow), 64'd0);
    done_drops(1'b0, "mac2_done_pulse");

    // WIDTH=4 wrap and sticky overflow
    do_op(1'b1, 2'b01, 23'd15, 23'd15, lat, bcnt);
    check("w4_mul_lat", 64'(lat), 64'd5);
    check("w4_mul_result", 64'(bus4.result), 64'd225);
    check("w4_mul_overflow", 64'(bus4.overflow), 64'd0);
    done_drops(1'b1, "w4_mul_done_pulse");
    do_op(1'b1, 2'b10, 23'd15, 23'd15, lat, bcnt);
    check("w4_mac_result", 64'(bus4.result), 64'd194);
    check("w4_mac_overflow", 64'(bus4.overflow), 64'd1);
    done_drops(1'b1, "w4_mac_done_pulse");
    check("w4_ovf_held", 64'(bus4.overflow), 64'd1);
    do_op(1'b1, 2'b11, 23'd9, 23'd9, lat, bcnt);
    check("w4_clr_lat", 64'(lat), 64'd1);
    check("w4_clr_result", 64'(bus4.result), 64'd0);
    check("w4_clr_overflow", 64'(bus4.overflow), 64'd0);
    done_drops(1'b1, "w4_clr_done_pulse");

    // Start pulses while busy must be ignored
    bus23.start = 1'b1; bus23.op = 2'b01; bus23.a = 23'd7; bus23.b = 23'd9;
    @(posedge clk); #1;
    cyc = 1; pulses = 0; first = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus23.done) begin
        pulses++;
        if (first == 0) first = cyc;
      end
      bus23.start = (i < 5); bus23.op = 2'b00; bus23.a = 23'd100; bus23.b = 23'd200;
      @(posedge clk); #1;
      cyc++;
    end
    bus23.start = 1'b0;
    check("ign_done_pulses", 64'(pulses), 64'd1);
    check("ign_first_done", 64'(first), 64'(LatRst == 24 ? 24 : 5));
    check("ign_result", 64'(bus23.result), 64'd63);

    // Reset in the middle of a multiply
    bus23.start = 1'b1; bus23.op = 2'b01; bus23.a = 23'd20; bus23.b = 23'h400005;
    @(posedge clk); #1;
    bus23.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("mid_busy_before_rst", 64'(bus23.busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(bus23.busy), 64'd0);
    check("mid_rst_done", 64'(bus23.done), 64'd0);
    check("mid_rst_result", 64'(bus23.result), 64'd0);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_busy", 64'(bus23.busy), 64'd0);
    do_op(1'b0, 2'b00, 23'd1, 23'd1, lat, bcnt);
    check("post_rst_add_lat", 64'(lat), 64'd1);
    check("post_rst_add_result", 64'(bus23.result), 64'd2);
    done_drops(1'b0, "post_rst_done_pulse");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
